// File: rtl/booth_mult_seq_ctrl.sv
// Operand-issue and result-capture sequencer for the 32x32 radix-4 Booth/Wallace
// multiplier. Holds an accepted md/mr pair at the multiplier inputs, pulses a
// one-cycle clear, waits LAT cycles, captures the product and hands it out over
// a valid/ready handshake.
module booth_mult_seq_ctrl #(
    parameter int N     = 32,
    parameter int LAT   = 18,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [N-1:0]   in_md,
    input  logic signed [N-1:0]   in_mr,
    output logic signed [N-1:0]   mult_md,
    output logic signed [N-1:0]   mult_mr,
    output logic                  mult_clr_n,
    input  logic signed [2*N-1:0] mult_product,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [2*N-1:0] out_product,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    // Latency counter only has to reach LAT (it steps once past LAT-1).
    localparam int              LC_W    = $clog2(LAT + 1);
    localparam logic [LC_W-1:0] LC_LAST = LC_W'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic signed [N-1:0]     r_md;
    logic signed [N-1:0]     r_mr;
    logic signed [2*N-1:0]   r_prod;
    logic [CNT_W-1:0]        r_op_cnt;
    logic [LC_W-1:0]         r_lat_cnt;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_out_hs;

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_state == S_RUN) && (r_lat_cnt == LC_LAST);
    assign w_out_hs = (r_state == S_DONE) & out_ready;

    assign mult_md     = r_md;
    assign mult_mr     = r_mr;
    assign out_product = r_prod;
    assign op_count    = r_op_cnt;

    // State register; an asynchronous reset drops any partial operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: in_valid only matters in IDLE and DONE, out_ready only in DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next_state = S_LOAD;
            S_LOAD: w_next_state = S_RUN;
            S_RUN:  if (w_last) w_next_state = S_DONE;
            S_DONE: if (out_ready) w_next_state = in_valid ? S_LOAD : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode; reset gates the handshake and holds the multiplier in clear.
    always_comb begin
        in_ready   = reset && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
        busy       = (r_state == S_LOAD) || (r_state == S_RUN);
        out_valid  = (r_state == S_DONE);
        mult_clr_n = reset && (r_state != S_LOAD);
    end

    // Operand hold registers: change only on an accepted handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md <= '0;
            r_mr <= '0;
        end else if (w_accept) begin
            r_md <= in_md;
            r_mr <= in_mr;
        end
    end

    // Latency counter: cleared while the multiplier is in clear, counts through RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lat_cnt <= '0;
        end else if (r_state == S_LOAD) begin
            r_lat_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_lat_cnt <= r_lat_cnt + LC_W'(1);
        end
    end

    // Product register: written only on the last RUN cycle, stable through DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prod <= '0;
        end else if (w_last) begin
            r_prod <= mult_product;
        end
    end

    // Completed-result counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op_cnt <= '0;
        end else if (w_out_hs) begin
            r_op_cnt <= r_op_cnt + CNT_W'(1);
        end
    end

endmodule
